inst_encoder: RTL and testbench
===============================

# inst_encoder

Streaming RV64I instruction encoder: the write-side counterpart of the core's immediate generator. It takes decoded fields (instruction kind, register numbers, 64-bit signed immediate), range-checks the immediate, and packs a 32-bit load, store or branch word together with its target word address. It sits between the self-test/boot sequencer and the instruction-memory write port, and uses a two-stage valid/ready pipeline with an address counter and statistics counters.

## Interface
- BASE_ADDR, 64'h0, byte address of the first emitted instruction
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  synchronous pulse: reload address to BASE_ADDR, clear counters
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept
- in_kind  in  2  00 ld, 01 sd, 10 beq, 11 illegal
- in_rd / in_rs1 / in_rs2  in  5 each  register numbers (unused fields ignored)
- in_imm  in  64  signed immediate / branch byte offset
- out_valid  out  1  encoded word valid
- out_ready  in  1  sink accepts
- out_inst  out  32  encoded instruction
- out_addr  out  64  byte address of out_inst
- out_err  out  1  request was illegal; out_inst is NOP
- enc_count  out  32  accepted outputs, wraps
- err_count  out  16  accepted outputs with out_err, saturates at 16'hFFFF

## Operation
- ld: {imm[11:0], rs1, 3'b011, rd, 7'b0000011}; legal iff imm[63:11] all equal.
- sd: {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011}; legal iff imm[63:11] all equal.
- beq: {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011}; legal iff imm[0]==0 and imm[63:12] all equal.
- Kind 11 or any failed check: out_inst = 32'h0000_0013 (NOP), out_err = 1; the item still consumes an address and is counted.
- Stage 1 registers the fields and the legality result; stage 2 registers the packed word and err.
- Address counter: out_addr is the current counter value; on out_valid && out_ready the counter advances by 4 (64-bit, wraps).
- On output handshake: enc_count += 1; if out_err, err_count += 1 unless already 16'hFFFF.
- start: the counter becomes BASE_ADDR and both statistics counters become 0 on the next edge. The pipeline is not flushed. If start coincides with a handshake, the handshaking item keeps its old address and is not counted; start wins.

## Timing
- Reset values: in_ready 1 is allowed only as a combinational result; all registers clear, so out_valid 0, out_inst 0, out_err 0, out_addr BASE_ADDR, counters 0. Both stage valids are 0.
- Latency: an item accepted at edge N presents out_valid at edge N+2 when not stalled.
- Throughput: 1 item per cycle.
- adv2 = !v2 || out_ready; adv1 = !v1 || adv2; in_ready = adv1 (combinational, no input-to-input loop through in_valid).
- out_valid, out_inst, out_err and out_addr are held stable while out_valid && !out_ready.
- Full pipeline (v1, v2 set) with out_ready=0: in_ready=0; no item lost or duplicated.
- Reset asserted mid-stream: in-flight items are dropped, with no output pulse after release until new input arrives.

## Structure
- The shared package holds the opcode constants (LOAD 7'h03, STORE 7'h23, BRANCH 7'h63), funct3 values, the kind encoding, and NOP 32'h0000_0013.
- One combinational sub-module, inst_pack: fields -> {inst32, err}. It is instantiated between stage 1 and stage 2 so the packing can be reused by the assembler bench model.

## Test plan
- ld, rd=5, rs1=10, imm=8 -> out_inst 32'h0085_3283, err 0, out_addr BASE_ADDR, two cycles after acceptance.
- sd, rs2=6, rs1=2, imm=-16 -> 32'hFE61_3823. Back-to-back with the previous item -> addr BASE_ADDR+4, 1/cycle.
- beq, rs1=1, rs2=2, imm=-4 -> 32'hFE20_8EE3. The following items are errors: ld with imm=2048; beq with imm=3; kind 11. Each gives 32'h0000_0013 with err 1, and err_count increments by 3.
- Random out_ready backpressure over 1000 random items -> in-order, no loss or duplication. The output is held stable while stalled. enc_count equals the number of handshakes. The packed word matches the reference model.
- start asserted in the same cycle as a handshake -> that item keeps its old address. The next item is at BASE_ADDR, and the counters read 0 then 1.
- rst_n pulled low with 2 items in flight -> out_valid is 0 immediately and stays 0 after release. out_addr is BASE_ADDR.

Source files
------------

// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg
//   Shared definitions for the RV64I load/store/branch encoder:
//   - kind encoding of an encode request
//   - opcode / funct3 constants and the canonical NOP word
//   - stage-1 field record and the immediate range check
package inst_encoder_pkg;

  typedef enum logic [1:0] {
    KIND_LD  = 2'b00,
    KIND_SD  = 2'b01,
    KIND_BEQ = 2'b10,
    KIND_ILL = 2'b11
  } kind_e;

  localparam logic [6:0]  OP_LOAD   = 7'h03;
  localparam logic [6:0]  OP_STORE  = 7'h23;
  localparam logic [6:0]  OP_BRANCH = 7'h63;

  localparam logic [2:0]  F3_LD     = 3'b011;
  localparam logic [2:0]  F3_SD     = 3'b011;
  localparam logic [2:0]  F3_BEQ    = 3'b000;

  localparam logic [31:0] NOP       = 32'h0000_0013;

  // Everything the packer needs once the immediate has been range-checked:
  // 13 immediate bits cover the widest field (branch offset imm[12:1]).
  typedef struct packed {
    kind_e       kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic        legal;
  } fields_t;

  // An immediate fits an N-bit signed field when all bits from the field's
  // sign bit upward are copies of each other.
  function automatic logic imm_legal(kind_e kind, logic [63:0] imm);
    logic ok;
    ok = 1'b0;
    case (kind)
      KIND_LD, KIND_SD: ok = (&imm[63:11]) || !(|imm[63:11]);
      KIND_BEQ:         ok = !imm[0] && ((&imm[63:12]) || !(|imm[63:12]));
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// inst_pack
//   Purely combinational packer: stage-1 field record -> 32-bit instruction
//   word plus error flag. Illegal kinds or out-of-range immediates produce
//   the NOP word with err set.
//   Ports:
//     f     in   fields_t  kind, registers, low immediate bits, legality
//     inst  out  32        packed instruction word
//     err   out  1         request was illegal
module inst_pack
  import inst_encoder_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] inst,
  output logic        err
);

  always_comb begin
    inst = NOP;
    err  = 1'b1;
    if (f.legal) begin
      err = 1'b0;
      case (f.kind)
        KIND_LD:  inst = {f.imm[11:0], f.rs1, F3_LD, f.rd, OP_LOAD};
        KIND_SD:  inst = {f.imm[11:5], f.rs2, f.rs1, F3_SD, f.imm[4:0], OP_STORE};
        KIND_BEQ: inst = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, F3_BEQ,
                          f.imm[4:1], f.imm[11], OP_BRANCH};
        default: begin
          inst = NOP;
          err  = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder
//   Streaming RV64I ld/sd/beq encoder with a two-stage valid/ready pipeline.
//   Stage 1 holds the request fields and the immediate legality result,
//   stage 2 holds the packed word and error flag. An address counter tags
//   each output with its byte address; statistics count accepted outputs.
//   Ports:
//     clk, rst_n             clock, asynchronous active-low reset
//     start                  reload address to BASE_ADDR and clear counters
//     in_valid/in_ready      request handshake
//     in_kind, in_rd, in_rs1, in_rs2, in_imm   decoded request fields
//     out_valid/out_ready    result handshake
//     out_inst, out_addr, out_err              encoded word, address, error
//     enc_count              accepted outputs (wraps)
//     err_count              accepted outputs with error (saturates)
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_addr,
  output logic        out_err,
  output logic [31:0] enc_count,
  output logic [15:0] err_count
);

  logic        v1_reg;
  logic        v2_reg;
  fields_t     s1_reg;
  fields_t     fields_in;
  logic [31:0] inst_reg;
  logic        err_reg;
  logic [31:0] pack_inst;
  logic        pack_err;

  logic [63:0] addr_reg, addr_next;
  logic [31:0] enc_reg,  enc_next;
  logic [15:0] errc_reg, errc_next;

  logic adv1, adv2, out_hs;

  // Ready chain depends only on state and out_ready, never on in_valid.
  assign adv2     = !v2_reg || out_ready;
  assign adv1     = !v1_reg || adv2;
  assign in_ready = adv1;
  assign out_hs   = v2_reg && out_ready;

  always_comb begin
    fields_in.kind  = kind_e'(in_kind);
    fields_in.rd    = in_rd;
    fields_in.rs1   = in_rs1;
    fields_in.rs2   = in_rs2;
    fields_in.imm   = in_imm[12:0];
    fields_in.legal = imm_legal(kind_e'(in_kind), in_imm);
  end

  inst_pack u_pack (
    .f    (s1_reg),
    .inst (pack_inst),
    .err  (pack_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg   <= 1'b0;
      v2_reg   <= 1'b0;
      s1_reg   <= '0;
      inst_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      if (adv1) begin
        v1_reg <= in_valid;
        if (in_valid) s1_reg <= fields_in;
      end
      if (adv2) begin
        v2_reg <= v1_reg;
        if (v1_reg) begin
          inst_reg <= pack_inst;
          err_reg  <= pack_err;
        end
      end
    end
  end

  // start takes priority over a coinciding handshake: the departing item
  // already carries its old address, and it is not counted.
  always_comb begin
    addr_next = addr_reg;
    enc_next  = enc_reg;
    errc_next = errc_reg;
    if (start) begin
      addr_next = BASE_ADDR;
      enc_next  = '0;
      errc_next = '0;
    end else if (out_hs) begin
      addr_next = addr_reg + 64'd4;
      enc_next  = enc_reg + 32'd1;
      if (err_reg && (errc_reg != 16'hFFFF)) errc_next = errc_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= BASE_ADDR;
      enc_reg  <= '0;
      errc_reg <= '0;
    end else begin
      addr_reg <= addr_next;
      enc_reg  <= enc_next;
      errc_reg <= errc_next;
    end
  end

  assign out_valid = v2_reg;
  assign out_inst  = inst_reg;
  assign out_err   = err_reg;
  assign out_addr  = addr_reg;
  assign enc_count = enc_reg;
  assign err_count = errc_reg;

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder
//   Directed table of encode requests with hand-computed words, plus
//   sequences for latency, random backpressure, start/handshake collision
//   and mid-stream reset. A negedge monitor scoreboards every output.
module tb_inst_encoder;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_addr;
  logic        out_err;
  logic [31:0] enc_count;
  logic [15:0] err_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int hs_total  = 0;
  int mode      = 0;   // 0: out_ready high, 1: random, 2: out_ready low

  exp_t exp_q[$];

  logic [63:0] m_addr;
  logic [31:0] m_enc;
  logic [15:0] m_errc;
  logic        prev_stall;
  logic [31:0] prev_inst;
  logic [63:0] prev_addr;
  logic        prev_err;

  inst_encoder #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference encoder written from the ISA field layout, range-checked with
  // signed arithmetic.
  function automatic logic [32:0] ref_enc(input logic [1:0] k, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [63:0] imm);
    longint      s;
    logic        ok;
    logic [31:0] w;
    s  = imm;
    ok = 1'b0;
    w  = 32'h0000_0013;
    case (k)
      2'b00: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = {imm[11:0], rs1, 3'b011, rd, 7'b0000011};
      end
      2'b01: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
      end
      2'b10: begin
        ok = (s >= -4096) && (s <= 4094) && (imm[0] == 1'b0);
        w  = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      end
      default: ok = 1'b0;
    endcase
    if (ok) return {1'b0, w};
    return {1'b1, 32'h0000_0013};
  endfunction

  function automatic logic pick_ready();
    if (mode == 0) return 1'b1;
    if (mode == 1) return ($urandom_range(0, 9) < 6);
    return 1'b0;
  endfunction

  function automatic vec_t rand_vec();
    vec_t        v;
    logic [31:0] u;
    logic [32:0] r;
    u      = $urandom;
    v.kind = u[1:0];
    v.rd   = u[6:2];
    v.rs1  = u[11:7];
    v.rs2  = u[16:12];
    u      = $urandom;
    case ($urandom_range(0, 4))
      0: v.imm = {{51{u[12]}}, u[12:0]};
      1: v.imm = {{53{u[10]}}, u[10:0]};
      2: v.imm = {$urandom, $urandom};
      default: begin
        case ($urandom_range(0, 7))
          0: v.imm = 64'd2047;
          1: v.imm = 64'd2048;
          2: v.imm = 64'hFFFF_FFFF_FFFF_F800;
          3: v.imm = 64'hFFFF_FFFF_FFFF_F7FF;
          4: v.imm = 64'd4094;
          5: v.imm = 64'd4096;
          6: v.imm = 64'hFFFF_FFFF_FFFF_F000;
          default: v.imm = 64'hFFFF_FFFF_FFFF_EFFE;
        endcase
      end
    endcase
    r      = ref_enc(v.kind, v.rd, v.rs1, v.rs2, v.imm);
    v.inst = r[31:0];
    v.err  = r[32];
    return v;
  endfunction

  // Hold the request until accepted; expected result is queued at acceptance.
  task automatic offer(input vec_t v, output int waited);
    logic acc;
    exp_t e;
    acc      = 1'b0;
    waited   = 0;
    in_valid = 1'b1;
    in_kind  = v.kind;
    in_rd    = v.rd;
    in_rs1   = v.rs1;
    in_rs2   = v.rs2;
    in_imm   = v.imm;
    while (!acc && waited < 200) begin
      out_ready = pick_ready();
      #1;
      if (in_ready) begin
        acc    = 1'b1;
        e.inst = v.inst;
        e.err  = v.err;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    chk("offer_accepted", acc, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      out_ready = pick_ready();
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Output monitor / scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic eerr;
    if (!rst_n) begin
      exp_q.delete();
      m_addr     = BASE;
      m_enc      = '0;
      m_errc     = '0;
      prev_stall = 1'b0;
      chk("rst_out_valid", out_valid, 1'b0);
    end else begin
      chk("enc_count", enc_count, m_enc);
      chk("err_count", err_count, m_errc);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_inst", out_inst, prev_inst);
        chk("hold_err", out_err, prev_err);
        chk("hold_addr", out_addr, prev_addr);
      end
      eerr = out_err;
      if (out_valid && out_ready) begin
        hs_total++;
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_output: got inst %08h, expected no output", out_inst);
        end else begin
          e    = exp_q.pop_front();
          eerr = e.err;
          $display("out addr=%016h inst=%08h err=%0d", out_addr, out_inst, out_err);
          chk("out_inst", out_inst, e.inst);
          chk("out_err", out_err, e.err);
          chk("out_addr", out_addr, m_addr);
        end
      end
      if (start) begin
        m_addr = BASE;
        m_enc  = '0;
        m_errc = '0;
      end else if (out_valid && out_ready) begin
        m_addr = m_addr + 64'd4;
        m_enc  = m_enc + 32'd1;
        if (eerr && m_errc != 16'hFFFF) m_errc = m_errc + 16'd1;
      end
      prev_stall = out_valid && !out_ready;
      prev_inst  = out_inst;
      prev_err   = out_err;
      prev_addr  = out_addr;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t tab[13];

  initial begin
    int          waited;
    int          n_err;
    int          hs0;
    logic [15:0] errc0;
    vec_t        v;

    tab[0]  = '{2'b00, 5'd5,  5'd10, 5'd0,  64'd8,                  32'h0085_3283, 1'b0};
    tab[1]  = '{2'b01, 5'd0,  5'd2,  5'd6,  64'hFFFF_FFFF_FFFF_FFF0, 32'hFE61_3823, 1'b0};
    tab[2]  = '{2'b10, 5'd0,  5'd1,  5'd2,  64'hFFFF_FFFF_FFFF_FFFC, 32'hFE20_8EE3, 1'b0};
    tab[3]  = '{2'b00, 5'd3,  5'd4,  5'd0,  64'd2048,               32'h0000_0013, 1'b1};
    tab[4]  = '{2'b10, 5'd0,  5'd1,  5'd2,  64'd3,                  32'h0000_0013, 1'b1};
    tab[5]  = '{2'b11, 5'd1,  5'd1,  5'd1,  64'd0,                  32'h0000_0013, 1'b1};
    tab[6]  = '{2'b00, 5'd1,  5'd2,  5'd0,  64'hFFFF_FFFF_FFFF_F800, 32'h8001_3083, 1'b0};
    tab[7]  = '{2'b01, 5'd0,  5'd0,  5'd31, 64'd2047,               32'h7FF0_3FA3, 1'b0};
    tab[8]  = '{2'b10, 5'd0,  5'd3,  5'd4,  64'd4094,               32'h7E41_8FE3, 1'b0};
    tab[9]  = '{2'b10, 5'd0,  5'd0,  5'd0,  64'hFFFF_FFFF_FFFF_F000, 32'h8000_0063, 1'b0};
    tab[10] = '{2'b10, 5'd0,  5'd1,  5'd1,  64'd4096,               32'h0000_0013, 1'b1};
    tab[11] = '{2'b01, 5'd0,  5'd1,  5'd1,  64'hFFFF_FFFF_FFFF_F7FF, 32'h0000_0013, 1'b1};
    tab[12] = '{2'b00, 5'd1,  5'd1,  5'd0,  64'h8000_0000_0000_0000, 32'h0000_0013, 1'b1};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_inst",  out_inst,  32'h0);
    chk("reset_out_err",   out_err,   1'b0);
    chk("reset_out_addr",  out_addr,  BASE);
    chk("reset_enc_count", enc_count, 32'h0);
    chk("reset_err_count", err_count, 16'h0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed table, back-to-back with out_ready high: one item per cycle
    mode  = 0;
    n_err = 0;
    errc0 = m_errc;
    for (int i = 0; i < 13; i++) begin
      $display("in  kind=%0d rd=%0d rs1=%0d rs2=%0d imm=%016h exp=%08h err=%0d",
               tab[i].kind, tab[i].rd, tab[i].rs1, tab[i].rs2, tab[i].imm,
               tab[i].inst, tab[i].err);
      offer(tab[i], waited);
      chk("table_throughput", waited, 1);
      if (tab[i].err) n_err++;
    end
    drain();
    chk("table_err_delta", err_count - errc0, n_err);
    chk("table_enc_total", enc_count, 13);

    // Latency: accepted at edge N, visible after edge N+1, taken at N+2
    offer(tab[0], waited);
    chk("lat_after_n", out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_after_n1", out_valid, 1'b1);
    chk("lat_inst", out_inst, 32'h0085_3283);
    chk("lat_addr", out_addr, BASE + 64'd52);
    drain();

    // Random items under random backpressure
    mode = 1;
    hs0  = hs_total;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid  = 1'b0;
        out_ready = pick_ready();
        @(posedge clk);
        #1;
      end
      v = rand_vec();
      offer(v, waited);
    end
    drain();
    chk("rand_handshakes", hs_total - hs0, 1000);
    chk("rand_enc_count", enc_count, 32'(hs_total));

    // start in the same cycle as a handshake
    mode = 0;
    offer(tab[1], waited);
    offer(tab[0], waited);
    start = 1'b1;
    #1;
    chk("start_hs_valid", out_valid, 1'b1);
    chk("start_hs_inst", out_inst, 32'hFE61_3823);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_enc_zero", enc_count, 32'h0);
    chk("start_err_zero", err_count, 16'h0);
    chk("start_next_valid", out_valid, 1'b1);
    chk("start_next_addr", out_addr, BASE);
    @(posedge clk);
    #1;
    chk("start_enc_one", enc_count, 32'h1);
    chk("start_addr_adv", out_addr, BASE + 64'd4);

    // Reset with two items in flight
    mode = 2;
    offer(tab[2], waited);
    offer(tab[6], waited);
    out_ready = 1'b0;
    #1;
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_addr", out_addr, BASE);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("post_rst_valid", out_valid, 1'b0);
    end
    chk("post_rst_addr", out_addr, BASE);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
